// File: rtl/eth_tx_pkg.sv
// Shared definitions for the GMII transmit path: arbiter FSM states and
// default framing/timing constants.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  localparam int DEF_N_REQ         = 3;
  localparam int DEF_IFG_CYCLES    = 12;
  localparam int DEF_GRANT_TIMEOUT = 64;
  localparam int DEF_MAX_FRAME     = 1526;

  // Width shared by the byte counter and the grant/gap timer.
  localparam int CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request found when
// scanning upward from the requester after last_winner, wrapping at N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] winner
);

  logic found;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && (j == (int'(last_winner) + i) % N_REQ)) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Grants one requester at a time onto the shared GMII TX buffer, muxes its
// tx_en/txd with one cycle of latency, and enforces timeout, size and IFG.
module gmii_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int IFG_CYCLES    = DEF_IFG_CYCLES,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int MAX_FRAME     = DEF_MAX_FRAME
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               eth_10_100m_en,
  input  logic               link,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   tx_en_in,
  input  logic [8*N_REQ-1:0] txd_in,
  output logic [N_REQ-1:0]   grant,
  output logic               gmii_tx_en,
  output logic [7:0]         gmii_txd,
  output logic               busy,
  output logic               timeout_pulse,
  output logic               oversize_pulse
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_1G    = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_SLOW  = CNT_W'(2 * IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(MAX_FRAME);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tx_state_e          state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [IDX_W-1:0]   last_winner, last_nxt;
  logic [CNT_W-1:0]   tmr, tmr_nxt;
  logic [CNT_W-1:0]   byte_cnt, byte_nxt;
  logic               armed;
  logic               tx_en_nxt, to_nxt, ov_nxt;
  logic [7:0]         txd_nxt;
  logic [N_REQ-1:0]   rr_winner;
  logic [IDX_W-1:0]   win_idx;
  logic               w_en;
  logic [7:0]         w_d;
  logic [CNT_W-1:0]   gap_len;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req         (req),
    .last_winner (last_winner),
    .winner      (rr_winner)
  );

  // The registered grant selects the active lane, so other requesters' tx_en never leaks through.
  always_comb begin
    win_idx = '0;
    w_d     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rr_winner[j]) win_idx = IDX_W'(j);
      if (grant[j])     w_d     = w_d | txd_in[8*j +: 8];
    end
    w_en = |(tx_en_in & grant);
  end

  assign gap_len = eth_10_100m_en ? GAP_SLOW : GAP_1G;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_winner;
    tmr_nxt   = tmr;
    byte_nxt  = byte_cnt;
    tx_en_nxt = 1'b0;
    txd_nxt   = '0;
    to_nxt    = 1'b0;
    ov_nxt    = 1'b0;
    if (!link) begin
      state_nxt = ST_IDLE;
      grant_nxt = '0;
      tmr_nxt   = '0;
      byte_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed && (|req)) begin
            state_nxt = ST_GRANT;
            grant_nxt = rr_winner;
            last_nxt  = win_idx;
            tmr_nxt   = '0;
            byte_nxt  = '0;
          end
        end
        ST_GRANT: begin
          tx_en_nxt = w_en;
          txd_nxt   = w_d;
          if (w_en) begin
            state_nxt = ST_SEND;
            byte_nxt  = CNT_ONE;
          end else if (tmr == TMO_LAST) begin
            state_nxt = ST_GAP;
            grant_nxt = '0;
            to_nxt    = 1'b1;
            tmr_nxt   = gap_len;
          end else begin
            tmr_nxt = tmr + CNT_ONE;
          end
        end
        ST_SEND: begin
          tx_en_nxt = w_en;
          txd_nxt   = w_d;
          // A byte beyond MAX_FRAME is dropped; the frame ends with a truncation pulse.
          if (w_en && (byte_cnt == FRAME_MAX)) begin
            tx_en_nxt = 1'b0;
            txd_nxt   = '0;
            ov_nxt    = 1'b1;
            state_nxt = ST_GAP;
            grant_nxt = '0;
            tmr_nxt   = gap_len;
          end else if (!w_en) begin
            state_nxt = ST_GAP;
            grant_nxt = '0;
            tmr_nxt   = gap_len;
          end else begin
            byte_nxt = byte_cnt + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (tmr == '0) state_nxt = ST_IDLE;
          else           tmr_nxt   = tmr - CNT_ONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments and an async active-low reset; nothing here is a memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      grant          <= '0;
      last_winner    <= '0;
      tmr            <= '0;
      byte_cnt       <= '0;
      armed          <= 1'b0;
      gmii_tx_en     <= 1'b0;
      gmii_txd       <= '0;
      timeout_pulse  <= 1'b0;
      oversize_pulse <= 1'b0;
    end else begin
      state          <= state_nxt;
      grant          <= grant_nxt;
      last_winner    <= last_nxt;
      tmr            <= tmr_nxt;
      byte_cnt       <= byte_nxt;
      armed          <= 1'b1;
      gmii_tx_en     <= tx_en_nxt;
      gmii_txd       <= txd_nxt;
      timeout_pulse  <= to_nxt;
      oversize_pulse <= ov_nxt;
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter: a transaction-level owner/gap model predicts every
// output each cycle, and directed scenarios pin lengths, orders and gaps.
module tb_gmii_tx_arbiter;

  localparam int N_REQ = 3;
  localparam int IFG   = 12;
  localparam int TMO   = 64;
  localparam int MAXF  = 1526;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        eth = 1'b0;
  logic        link = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [2:0]  tx_en_in = 3'b000;
  logic [23:0] txd_in = 24'h0;
  logic [2:0]  grant;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        busy, timeout_pulse, oversize_pulse;

  gmii_tx_arbiter #(
    .N_REQ(N_REQ), .IFG_CYCLES(IFG), .GRANT_TIMEOUT(TMO), .MAX_FRAME(MAXF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .eth_10_100m_en (eth),
    .link           (link),
    .req            (req),
    .tx_en_in       (tx_en_in),
    .txd_in         (txd_in),
    .grant          (grant),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_txd       (gmii_txd),
    .busy           (busy),
    .timeout_pulse  (timeout_pulse),
    .oversize_pulse (oversize_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: who owns the bus, how long it has waited/sent, how much gap remains.
  int   m_owner = -1;
  int   m_last = 0;
  int   m_waited = 0;
  int   m_sent = 0;
  int   m_gap = 0;
  bit   m_armed = 1'b0;
  logic e_en = 1'b0, e_to = 1'b0, e_ov = 1'b0;
  logic [7:0] e_d = 8'h0;

  task automatic end_frame();
    m_owner = -1;
    m_gap   = eth ? 2 * IFG : IFG;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_last = 0; m_waited = 0; m_sent = 0; m_gap = 0; m_armed = 1'b0;
      e_en = 1'b0; e_d = 8'h0; e_to = 1'b0; e_ov = 1'b0;
    end else begin
      e_en = 1'b0; e_d = 8'h0; e_to = 1'b0; e_ov = 1'b0;
      if (!link) begin
        m_owner = -1;
        m_gap   = 0;
      end else if (m_owner >= 0) begin
        e_en = 1'(tx_en_in >> m_owner);
        e_d  = 8'(txd_in >> (8 * m_owner));
        if (e_en && m_sent == MAXF) begin
          e_en = 1'b0; e_d = 8'h0; e_ov = 1'b1;
          end_frame();
        end else if (e_en) begin
          m_sent++;
        end else if (m_sent > 0) begin
          end_frame();
        end else begin
          m_waited++;
          if (m_waited == TMO) begin
            e_to = 1'b1;
            end_frame();
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (m_armed && req != 3'b000) begin
        for (int k = 1; k <= N_REQ; k++) begin
          int c;
          c = (m_last + k) % N_REQ;
          if (m_owner < 0 && 1'(req >> c)) m_owner = c;
        end
        m_last = m_owner; m_sent = 0; m_waited = 0;
      end
      m_armed = 1'b1;
    end
  end

  // Requester agents: the owner plays its configured frame, everyone else drives noise.
  int cfg_delay [3] = '{0, 0, 0};
  int cfg_len   [3] = '{0, 0, 0};
  int ag_prev = -1, ag_wait = 0, ag_left = 0, ag_seq = 0;

  always @(posedge clk) begin
    logic [2:0]  en_v;
    logic [23:0] d_v;
    #1;
    en_v = 3'($urandom);
    d_v  = 24'($urandom);
    for (int i = 0; i < N_REQ; i++) begin
      if (m_owner == i) begin
        if (ag_prev != i) begin
          ag_wait = cfg_delay[i]; ag_left = cfg_len[i]; ag_seq = 0;
        end
        en_v = en_v & ~3'(1 << i);
        if (ag_wait > 0) begin
          ag_wait--;
        end else if (ag_left > 0) begin
          en_v = en_v | 3'(1 << i);
          d_v  = (d_v & ~(24'hFF << (8 * i))) | (24'(8'(ag_seq * 7 + i * 50 + 1)) << (8 * i));
          ag_seq++;
          ag_left--;
        end
      end
    end
    ag_prev  = m_owner;
    tx_en_in = en_v;
    txd_in   = d_v;
  end

  // Per-cycle comparison plus running measurements for the directed checks.
  int  en_cnt = 0, to_cnt = 0, ov_cnt = 0, g2_cnt = 0, cyc = 0;
  int  en_fall_cyc = 0, busy_fall_cyc = 0, idle_run = 0;
  bit  prev_en = 1'b0, prev_busy = 1'b0, seen_en = 1'b0;
  logic [2:0] prev_grant = 3'b000;
  logic [2:0] grant_log [$];
  int  idle_runs [$];

  always @(negedge clk) begin
    logic [2:0] exp_grant;
    exp_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    check("cycle", {grant, gmii_tx_en, gmii_txd, busy, timeout_pulse, oversize_pulse},
          {exp_grant, e_en, e_d, (m_owner >= 0 || m_gap > 0), e_to, e_ov});
    check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    cyc++;
    if (gmii_tx_en) en_cnt++;
    if (timeout_pulse) to_cnt++;
    if (oversize_pulse) ov_cnt++;
    if (grant[2]) g2_cnt++;
    if (prev_en && !gmii_tx_en) en_fall_cyc = cyc;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    if (grant != 3'b000 && grant != prev_grant) grant_log.push_back(grant);
    if (gmii_tx_en) begin
      if (seen_en && idle_run > 0) idle_runs.push_back(idle_run);
      idle_run = 0;
      seen_en  = 1'b1;
    end else begin
      idle_run++;
    end
    prev_en    = gmii_tx_en;
    prev_busy  = busy;
    prev_grant = grant;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input string nm, input logic [2:0] target, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (grant == target) begin ok = 1'b1; break; end
      step();
    end
    check(nm, 64'(ok), 64'd1);
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    int q = 0;
    for (int k = 0; k < budget && q < 3; k++) begin
      step();
      if (!busy) q++; else q = 0;
    end
    check(nm, 64'(q >= 3), 64'd1);
  endtask

  task automatic wait_bytes(input string nm, input int base, input int n, input int budget);
    for (int k = 0; k < budget && (en_cnt - base) < n; k++) step();
    check(nm, 64'((en_cnt - base) >= n), 64'd1);
  endtask

  initial begin
    automatic int base_en, base_ov, base_to, base_g2, base_log, base_idle, min_run;
    automatic logic [2:0] exp_order [4] = '{3'b010, 3'b100, 3'b001, 3'b010};

    // Reset state and the two-edge arbitration holdoff.
    #2 rst_n = 1'b0;
    repeat (3) step();
    check("reset_outputs", {grant, gmii_tx_en, gmii_txd, busy, timeout_pulse, oversize_pulse}, 64'd0);
    req = 3'b001; cfg_delay[0] = 2; cfg_len[0] = 60;
    rst_n = 1'b1;
    step();
    check("no_grant_edge1", grant, 3'b000);
    step();
    check("grant_edge2", grant, 3'b001);

    // Single requester, 60-byte frame; req drop after grant has no effect.
    base_en = en_cnt;
    req = 3'b000;
    wait_quiet("single_done", 400);
    check("single_len", en_cnt - base_en, 60);
    check("single_busy_tail", busy_fall_cyc - en_fall_cyc, 12);

    // Contention: round-robin order and inter-frame spacing.
    for (int i = 0; i < N_REQ; i++) begin cfg_delay[i] = 1; cfg_len[i] = 20; end
    base_log = grant_log.size(); base_idle = idle_runs.size();
    req = 3'b111;
    for (int k = 0; k < 1000 && grant_log.size() < base_log + 4; k++) step();
    req = 3'b000;
    wait_quiet("rr_done", 400);
    check("rr_grants_seen", 64'(grant_log.size() - base_log), 64'd4);
    for (int k = 0; k < 4; k++)
      if (grant_log.size() > base_log + k) check($sformatf("rr_order%0d", k), grant_log[base_log + k], exp_order[k]);
    min_run = 1000;
    for (int k = base_idle + 1; k < idle_runs.size(); k++)
      if (idle_runs[k] < min_run) min_run = idle_runs[k];
    check("rr_gap_runs", 64'(idle_runs.size() - base_idle), 64'd4);
    check("rr_min_ifg_ok", 64'(min_run >= IFG), 64'd1);

    // Timeout on requester 2, then requester 0 is served.
    cfg_len[2] = 0; cfg_delay[0] = 0; cfg_len[0] = 10;
    base_to = to_cnt; base_g2 = g2_cnt;
    req = 3'b101;
    wait_grant("timeout_next_grant", 3'b001, 400);
    req = 3'b000;
    wait_quiet("timeout_done", 400);
    check("timeout_grant_cycles", g2_cnt - base_g2, TMO);
    check("timeout_pulses", to_cnt - base_to, 1);
    check("timeout_prev_grant", grant_log[grant_log.size() - 2], 3'b100);

    // Oversize: 2000-byte attempt truncated at MAX_FRAME.
    cfg_delay[1] = 0; cfg_len[1] = 2000;
    base_en = en_cnt; base_ov = ov_cnt;
    req = 3'b010;
    wait_grant("oversize_grant", 3'b010, 100);
    req = 3'b000;
    wait_quiet("oversize_done", 3000);
    check("oversize_len", en_cnt - base_en, MAXF);
    check("oversize_pulses", ov_cnt - base_ov, 1);
    check("oversize_grant_clear", grant, 3'b000);

    // Exactly MAX_FRAME bytes: full frame, no truncation.
    cfg_len[1] = MAXF;
    base_en = en_cnt; base_ov = ov_cnt;
    req = 3'b010;
    wait_grant("maxlen_grant", 3'b010, 100);
    req = 3'b000;
    wait_quiet("maxlen_done", 3000);
    check("maxlen_len", en_cnt - base_en, MAXF);
    check("maxlen_pulses", ov_cnt - base_ov, 0);

    // 10/100 mode doubles the gap.
    eth = 1'b1; cfg_len[2] = 10;
    req = 3'b100;
    wait_grant("slow_grant", 3'b100, 100);
    req = 3'b000;
    wait_quiet("slow_done", 400);
    check("slow_gap", busy_fall_cyc - en_fall_cyc, 2 * IFG);
    eth = 1'b0;

    // Link drop mid-frame clears everything on the next edge.
    cfg_len[0] = 100;
    base_en = en_cnt;
    req = 3'b001;
    wait_grant("link_grant", 3'b001, 100);
    req = 3'b000;
    wait_bytes("link_midframe", base_en, 20, 200);
    check("link_pre_en", gmii_tx_en, 1'b1);
    link = 1'b0;
    step();
    check("link_drop", {grant, gmii_tx_en, busy}, 5'b000_0_0);
    repeat (3) step();
    link = 1'b1;
    repeat (3) step();
    check("link_restore_idle", busy, 1'b0);

    // Async reset mid-frame, then normal service.
    cfg_len[1] = 100;
    base_en = en_cnt;
    req = 3'b010;
    wait_grant("rst_grant", 3'b010, 100);
    req = 3'b000;
    wait_bytes("rst_midframe", base_en, 10, 200);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {grant, gmii_tx_en, gmii_txd, busy, timeout_pulse, oversize_pulse}, 64'd0);
    repeat (2) step();
    cfg_len[0] = 30;
    req = 3'b001;
    rst_n = 1'b1;
    step();
    check("rst_no_grant_edge1", grant, 3'b000);
    step();
    check("rst_grant_edge2", grant, 3'b001);
    base_en = en_cnt;
    req = 3'b000;
    wait_quiet("rst_frame_done", 400);
    check("rst_frame_len", en_cnt - base_en, 30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
